// File: rtl/pipe_stage_skid_pkg.sv
// Shared definitions for elastic pipeline-stage buffers.
// State encodings double as entry occupancy counts.
package pipe_defs;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_CTRL_W = 8;
    localparam int DEF_CNT_W  = 8;

    function automatic logic [1:0] occ_of(state_e s);
        return s;
    endfunction

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Handshake and status bundle between a pipeline stage buffer
// and its neighbours; master drives the inputs, slave is the buffer.
interface pipe_stage_skid_if
    import pipe_defs::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CTRL_W = DEF_CTRL_W,
    parameter int CNT_W  = DEF_CNT_W
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  drop_cnt;

    modport master (
        output flush, in_valid, in_data, in_ctrl, out_ready,
        input  in_ready, out_valid, out_data, out_ctrl,
        input  occupancy, drop_cnt
    );

    modport slave (
        input  flush, in_valid, in_data, in_ctrl, out_ready,
        output in_ready, out_valid, out_data, out_ctrl,
        output occupancy, drop_cnt
    );
endinterface

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating up-counter, increments by 0..3 per falling edge.
// Usable for flush-drop and stall statistics.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   inc_i,
    output logic [W-1:0] cnt_o
);
    localparam logic [W+1:0] MAX = {2'b00, {W{1'b1}}};

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic [W+1:0] sum;

    // Add with headroom and clamp at all-ones.
    always_comb begin
        sum   = {2'b00, cnt_q} + {{W{1'b0}}, inc_i};
        cnt_d = (sum > MAX) ? MAX[W-1:0] : sum[W-1:0];
    end

    // Counter register; cleared only by reset.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic two-entry pipeline-stage register with flush-to-bubble.
// Ready/valid outputs come straight from flops; state moves on falling edges.
module pipe_stage_skid
    import pipe_defs::*;
#(
    parameter int DATA_W         = DEF_DATA_W,
    parameter int CTRL_W         = DEF_CTRL_W,
    parameter bit CLEAR_ON_FLUSH = 1'b1,
    parameter int CNT_W          = DEF_CNT_W
) (
    input logic clk,
    input logic rst,
    pipe_stage_skid_if.slave bus
);
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [CTRL_W-1:0] ctrl;
    } beat_t;

    state_e     state_q, state_d;
    beat_t      main_q, main_d;
    beat_t      skid_q, skid_d;
    logic       in_ready_q;
    logic       out_valid_q;
    logic       accept;
    logic       pop;
    logic [1:0] drop_inc;
    beat_t      in_beat;

    assign in_beat = '{data: bus.in_data, ctrl: bus.in_ctrl};
    assign accept  = bus.in_valid & in_ready_q;
    assign pop     = out_valid_q & bus.out_ready;

    // Next-state and storage steering; flush overrides everything.
    always_comb begin
        state_d  = state_q;
        main_d   = main_q;
        skid_d   = skid_q;
        drop_inc = 2'd0;
        unique case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d = ST_ONE;
                    main_d  = in_beat;
                end
            end
            ST_ONE: begin
                if (accept && pop) begin
                    main_d = in_beat;
                end else if (accept) begin
                    state_d = ST_FULL;
                    skid_d  = in_beat;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (pop) begin
                    state_d = ST_ONE;
                    main_d  = skid_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (bus.flush) begin
            state_d  = ST_EMPTY;
            // The popped entry was already taken downstream.
            drop_inc = occ_of(state_q) + {1'b0, accept} - {1'b0, pop};
            if (CLEAR_ON_FLUSH) begin
                main_d = '0;
                skid_d = '0;
            end
        end
    end

    // State, storage and registered handshake flags.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= (state_d != ST_FULL);
            out_valid_q <= (state_d != ST_EMPTY);
        end
    end

    sat_counter #(.W(CNT_W)) u_drop (
        .clk   (clk),
        .rst   (rst),
        .inc_i (drop_inc),
        .cnt_o (bus.drop_cnt)
    );

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = main_q.data;
    assign bus.out_ctrl  = out_valid_q ? main_q.ctrl : '0;
    assign bus.occupancy = occ_of(state_q);
endmodule
